// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM breathing sequencer.
//   phase_e       : encoding of the sequencer phase, visible on the phase port
//   DUTY_W_DEF    : default duty width
//   calc_period() : PWM period in system clocks (CLK_FREQ / PWM_FREQ)
//   calc_div()    : step prescaler division ratio (CLK_FREQ / STEP_HZ)
package pwm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_RISE    = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_FALL    = 3'd3,
    PH_HOLD_LO = 3'd4
  } phase_e;

  localparam int unsigned DUTY_W_DEF = 16;

  function automatic int unsigned calc_period(input int unsigned clk_freq,
                                              input int unsigned pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned step_hz);
    return (clk_freq / step_hz < 1) ? 1 : clk_freq / step_hz;
  endfunction

endpackage

// File: rtl/pwm_step_prescaler.sv
// pwm_step_prescaler -- enable-gated divider producing the ramp step tick.
//   clk       in  : system clock
//   rst       in  : synchronous reset, active-high
//   enable    in  : count only while high; counter held at 0 while low
//   step_tick out : high for the one cycle where the count sits at DIV-1
module pwm_step_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic step_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign step_tick = enable && (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || step_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_breath_sequencer.sv
// pwm_breath_sequencer -- breathing duty-cycle source for a PWM core.
//   clk         in  : system clock
//   rst         in  : synchronous reset, active-high, beats every other event
//   enable      in  : run the sequencer; low returns to IDLE at next period_end
//   period_end  in  : 1-cycle pulse from the PWM core at its counter wrap
//   duty_cycle  out : duty to the PWM core (DUTY_W bits)
//   duty_update out : 1-cycle pulse in the cycle duty_cycle took a new value
//   phase       out : current sequencer state (phase_e encoding)
//   overrun     out : sticky, a step tick arrived while a step was pending
// Build option: define BREATH_HOLD_EN to dwell HOLD_STEPS applied steps at the
// top and bottom of the ramp; without it the profile is a pure triangle.
//
// Timing contract with the PWM core: a step is only ever applied in a cycle
// where period_end=1; duty_cycle is registered on that edge and duty_update is
// raised alongside it, so the core sees a new duty exactly at its period
// boundary and never mid-period. Ticks that arrive between boundaries are
// remembered in a single pending flag; they do not queue up.
module pwm_breath_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned PWM_FREQ   = 1_250,
  parameter int unsigned STEP_HZ    = 8,
  parameter int unsigned DUTY_W     = DUTY_W_DEF,
  parameter int unsigned DUTY_MIN   = 0,
  parameter int unsigned DUTY_MAX   = 14_000,
  parameter int unsigned STEP_SIZE  = 1,
  parameter int unsigned HOLD_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_update,
  output logic [2:0]        phase,
  output logic              overrun
);

  localparam int unsigned PERIOD   = calc_period(CLK_FREQ, PWM_FREQ);
  localparam int unsigned STEP_DIV = calc_div(CLK_FREQ, STEP_HZ);
  // A duty above the period is meaningless to the core; never ramp past it.
  localparam int unsigned CEIL     = (DUTY_MAX > PERIOD) ? PERIOD : DUTY_MAX;

  localparam logic [DUTY_W:0]   MIN_X  = (DUTY_W + 1)'(DUTY_MIN);
  localparam logic [DUTY_W:0]   MAX_X  = (DUTY_W + 1)'(CEIL);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(STEP_SIZE);
  localparam logic [DUTY_W-1:0] MIN_D  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(CEIL);

  logic step_tick;

  pwm_step_prescaler #(
    .DIV(STEP_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .step_tick (step_tick)
  );

  phase_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;

`ifdef BREATH_HOLD_EN
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic [DUTY_W:0]   sum_x;
  logic [DUTY_W:0]   dec_x;
  logic [DUTY_W-1:0] rise_val;
  logic [DUTY_W-1:0] fall_val;
  logic              apply;
  logic              abort;

  always_comb begin
    // Arithmetic is one bit wider than the duty so a step near the top of
    // the range cannot wrap before it is clamped.
    sum_x    = {1'b0, duty_q} + STEP_X;
    dec_x    = ({1'b0, duty_q} >= MIN_X + STEP_X) ? ({1'b0, duty_q} - STEP_X) : MIN_X;
    rise_val = (sum_x >= MAX_X) ? MAX_D : sum_x[DUTY_W-1:0];
    fall_val = dec_x[DUTY_W-1:0];
    apply    = period_end && (pending_q || step_tick);
    abort    = period_end && !enable;
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    pending_d = pending_q;
    overrun_d = overrun_q | (step_tick & pending_q);
`ifdef BREATH_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif

    // Any period boundary that either applies a step or aborts consumes
    // the pending step.
    if (apply || abort) begin
      pending_d = 1'b0;
    end else if (step_tick) begin
      pending_d = 1'b1;
    end

    if (state_q == PH_IDLE) begin
      duty_d = MIN_D;
      if (enable) begin
        state_d = PH_RISE;
      end
    end else if (abort) begin
      state_d = PH_IDLE;
      duty_d  = MIN_D;
    end else if (apply) begin
      case (state_q)
        PH_RISE: begin
          duty_d = rise_val;
          if (rise_val == MAX_D) begin
`ifdef BREATH_HOLD_EN
            state_d    = PH_HOLD_HI;
            hold_cnt_d = '0;
`else
            state_d = PH_FALL;
`endif
          end
        end
        PH_FALL: begin
          duty_d = fall_val;
          if (fall_val == MIN_D) begin
`ifdef BREATH_HOLD_EN
            state_d    = PH_HOLD_LO;
            hold_cnt_d = '0;
`else
            state_d = PH_RISE;
`endif
          end
        end
`ifdef BREATH_HOLD_EN
        PH_HOLD_HI, PH_HOLD_LO: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = (state_q == PH_HOLD_HI) ? PH_FALL : PH_RISE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = PH_IDLE;
          duty_d  = MIN_D;
        end
      endcase
    end

    upd_d = (duty_d != duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PH_IDLE;
      duty_q    <= MIN_D;
      upd_q     <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      upd_q     <= upd_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef BREATH_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign duty_cycle  = duty_q;
  assign duty_update = upd_q;
  assign phase       = state_q;
  assign overrun     = overrun_q;

endmodule
